seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_muldiv_iter.sv | 75 +++++++
 rtl/seq_alu.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU:
// opcodes, flag bit positions and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_XNOR = 4'h9,
    OP_NAND = 4'hA,
    OP_NOR  = 4'hB
  } op_e;

  localparam int unsigned FLG_ZERO = 0;
  localparam int unsigned FLG_SHC  = 1;
  localparam int unsigned FLG_OVF  = 2;
  localparam int unsigned FLG_BRW  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and
// restoring divider sharing one 2*WIDTH register.
module alu_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hi_nonzero
);
  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0]   m;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shf;
  logic [WIDTH:0]     dif;
  logic [CW-1:0]      cnt;
  logic               div_q;
  logic               busy;

  // One iteration step; the final step is consumed
  // directly so the last bit costs no extra cycle.
  always_comb begin
    sum = {1'b0, p[2*WIDTH-1:WIDTH]}
        + {1'b0, (p[0] ? m : {WIDTH{1'b0}})};
    shf = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    dif = shf - {1'b0, m};
    p_nxt = p;
    if (div_q) begin
      if (!dif[WIDTH])
        p_nxt = {dif[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
      else
        p_nxt = {shf[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    end else begin
      p_nxt = {sum, p[WIDTH-1:1]};
    end
  end

  assign done       = busy && (cnt == CW'(WIDTH-1));
  assign result     = p_nxt[WIDTH-1:0];
  assign hi_nonzero = |p_nxt[2*WIDTH-1:WIDTH];

  // Load operands on start, then iterate WIDTH times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p     <= '0;
      m     <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
      busy  <= 1'b0;
    end else if (start) begin
      p     <= op ? {{WIDTH{1'b0}}, a}
                  : {{WIDTH{1'b0}}, b};
      m     <= op ? b : a;
      cnt   <= '0;
      div_q <= op;
      busy  <= 1'b1;
    end else if (busy) begin
      p   <= p_nxt;
      cnt <= cnt + 1'b1;
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake;
// MUL/DIV run on the iterative datapath.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [3:0]       flags
);
  import alu_pkg::*;

  state_e           state;
  logic             accept;
  logic             start;
  logic             is_div;
  logic             multi;
  logic             zero_en;
  logic             b_big;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH-1:0] res;
  logic [3:0]       fl;
  logic             it_done;
  logic [WIDTH-1:0] it_res;
  logic             it_hi;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign start    = accept && multi;

  assign b_big = 32'(in_b) >= WIDTH;
  assign add_w = {1'b0, in_a} + {1'b0, in_b};
  assign shl_w = {1'b0, in_a} << in_b;
  assign shr_w = {in_a, 1'b0} >> in_b;

  // Single-cycle result/flags and multi-cycle detect.
  always_comb begin
    res     = '0;
    fl      = '0;
    multi   = 1'b0;
    zero_en = 1'b1;
    case (sel)
      OP_ADD: begin
        res         = add_w[WIDTH-1:0];
        fl[FLG_OVF] = add_w[WIDTH];
      end
      OP_SUB: begin
        res         = in_a - in_b;
        fl[FLG_BRW] = in_a < in_b;
      end
      OP_MUL: multi = 1'b1;
      OP_DIV: begin
        if (in_b == '0)
          fl[FLG_OVF] = 1'b1;
        else if (in_a < in_b)
          fl[FLG_BRW] = 1'b1;
        else
          multi = 1'b1;
      end
      OP_SHL: begin
        if (!b_big) begin
          res         = shl_w[WIDTH-1:0];
          fl[FLG_SHC] = shl_w[WIDTH];
        end
      end
      OP_SHR: begin
        if (!b_big) begin
          res         = shr_w[WIDTH:1];
          fl[FLG_SHC] = shr_w[0];
        end
      end
      OP_AND:  res = in_a & in_b;
      OP_OR:   res = in_a | in_b;
      OP_XOR:  res = in_a ^ in_b;
      OP_XNOR: res = ~(in_a ^ in_b);
      OP_NAND: res = ~(in_a & in_b);
      OP_NOR:  res = ~(in_a | in_b);
      default: zero_en = 1'b0;
    endcase
    fl[FLG_ZERO] = zero_en && (res == '0);
  end

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (sel == OP_DIV),
    .a          (in_a),
    .b          (in_b),
    .done       (it_done),
    .result     (it_res),
    .hi_nonzero (it_hi)
  );

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dout      <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      is_div    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            is_div <= (sel == OP_DIV);
            if (multi) begin
              state <= ST_BUSY;
            end else begin
              state     <= ST_DONE;
              dout      <= res;
              flags     <= fl;
              out_valid <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (it_done) begin
            state     <= ST_DONE;
            dout      <= it_res;
            flags     <= {1'b0, ~is_div & it_hi,
                          1'b0, it_res == '0};
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
